// File: rtl/npu_dot_engine.sv
// npu_dot_engine: INT8 dot-product engine that streams weight and input words
// from a single-port SRAM, multiplies LANES signed byte pairs per word and
// accumulates with saturation into a signed ACC_W-bit result.
// Optional build macro NPU_RELU_EN: when defined, the stored result is
// clamped at zero (max(acc,0)); the sat flag is not affected by that clamp.
module npu_dot_engine #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    input  logic                    cfg_wr,
    output logic [31:0]             cfg_rdata,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic                    sram_rd,
    input  logic [8*LANES-1:0]      sram_rdata,
    input  logic                    npu_start,
    output logic                    npu_busy,
    output logic                    npu_done,
    output logic [ACC_W-1:0]        result
);

    // A chunk sum of LANES products of two INT8 values needs 16 bits per
    // product plus log2(LANES) growth; the extended adder holds acc + chunk
    // without overflow so the clamp decision is exact.
    localparam int SUM_W = 17 + $clog2(LANES);
    localparam int EXT_W = ACC_W + SUM_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH_W, FETCH_X, CAPT, ACC, FIN} state_t;

    state_t                     r_state;
    state_t                     w_nextState;
    logic [31:0]                r_numElements;
    logic [ADDR_W-1:0]          r_weightBase;
    logic [ADDR_W-1:0]          r_inputBase;
    logic [31:0]                r_remaining;
    logic [ADDR_W-1:0]          r_k;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_result;
    logic                       r_sat;
    logic                       r_doneSticky;
    logic [8*LANES-1:0]         r_weights;
    logic [8*LANES-1:0]         r_inputs;

    logic signed [15:0]         w_prod [LANES];
    logic signed [SUM_W-1:0]    w_chunkSum;
    logic signed [EXT_W-1:0]    w_accExt;
    logic signed [ACC_W-1:0]    w_accNext;
    logic                       w_clamp;
    logic signed [ACC_W-1:0]    w_finValue;
    logic                       w_cfgWrite;

    assign result     = r_result;
    assign w_cfgWrite = cfg_wr && (r_state == IDLE);

`ifdef NPU_RELU_EN
    assign w_finValue = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign w_finValue = r_acc;
`endif

    // Per-lane signed INT8 x INT8 products of the captured words
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = $signed(r_weights[8*i +: 8]) * $signed(r_inputs[8*i +: 8]);
        end
    end

    // Sum of the products, masking lanes past the end of the vector
    always_comb begin
        w_chunkSum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (32'(i) < r_remaining) begin
                w_chunkSum = w_chunkSum
                           + $signed({{(SUM_W-16){w_prod[i][15]}}, w_prod[i]});
            end
        end
    end

    // Saturating add of the chunk sum into the accumulator
    always_comb begin
        w_accExt  = $signed({{SUM_W{r_acc[ACC_W-1]}}, r_acc})
                  + $signed({{ACC_W{w_chunkSum[SUM_W-1]}}, w_chunkSum});
        w_clamp   = 1'b0;
        w_accNext = w_accExt[ACC_W-1:0];
        if (w_accExt > EXT_W'(ACC_MAX)) begin
            w_accNext = ACC_MAX;
            w_clamp   = 1'b1;
        end else if (w_accExt < EXT_W'(ACC_MIN)) begin
            w_accNext = ACC_MIN;
            w_clamp   = 1'b1;
        end
    end

    // Combinational register read mux
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            8'h00:   cfg_rdata = r_numElements;
            8'h04:   cfg_rdata = 32'(r_weightBase);
            8'h08:   cfg_rdata = 32'(r_inputBase);
            8'h0C:   cfg_rdata = 32'(r_result);
            8'h10:   cfg_rdata = {29'b0, r_sat, npu_busy, r_doneSticky};
            default: cfg_rdata = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic; remaining > LANES means another chunk follows
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (npu_start) w_nextState = (r_numElements == 32'd0) ? FIN : FETCH_W;
            FETCH_W: w_nextState = FETCH_X;
            FETCH_X: w_nextState = CAPT;
            CAPT:    w_nextState = ACC;
            ACC:     w_nextState = (r_remaining > 32'(LANES)) ? FETCH_W : FIN;
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: SRAM strobes/addresses and handshake flags
    always_comb begin
        sram_rd   = 1'b0;
        sram_addr = '0;
        npu_busy  = (r_state != IDLE);
        npu_done  = (r_state == FIN);
        case (r_state)
            FETCH_W: begin
                sram_rd   = 1'b1;
                sram_addr = r_weightBase + r_k;
            end
            FETCH_X: begin
                sram_rd   = 1'b1;
                sram_addr = r_inputBase + r_k;
            end
            default: ;
        endcase
    end

    // Configuration registers, sticky flags and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_numElements <= 32'd16;
            r_weightBase  <= '0;
            r_inputBase   <= ADDR_W'(256);
            r_remaining   <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_sat         <= 1'b0;
            r_doneSticky  <= 1'b0;
            r_weights     <= '0;
            r_inputs      <= '0;
        end else begin
            if (w_cfgWrite && cfg_addr == 8'h00) r_numElements <= cfg_wdata;
            if (w_cfgWrite && cfg_addr == 8'h04) r_weightBase  <= cfg_wdata[ADDR_W-1:0];
            if (w_cfgWrite && cfg_addr == 8'h08) r_inputBase   <= cfg_wdata[ADDR_W-1:0];
            if (cfg_wr && cfg_addr == 8'h10) begin
                r_doneSticky <= 1'b0;
                r_sat        <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (npu_start) begin
                        r_acc       <= '0;
                        r_k         <= '0;
                        r_remaining <= r_numElements;
                    end
                end
                FETCH_X: r_weights <= sram_rdata;
                CAPT:    r_inputs  <= sram_rdata;
                ACC: begin
                    r_acc <= w_accNext;
                    if (w_clamp) r_sat <= 1'b1;
                    r_k <= r_k + 1'b1;
                    if (r_remaining > 32'(LANES)) r_remaining <= r_remaining - 32'(LANES);
                    else                          r_remaining <= '0;
                end
                FIN: begin
                    r_result     <= w_finValue;
                    r_doneSticky <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_dot_engine.sv
// Testbench for npu_dot_engine: directed corner runs plus randomized runs,
// each compared against a plain-arithmetic dot-product model. ACC_W is set
// to 16 so that saturation is reachable with short vectors.
module tb_npu_dot_engine;

    localparam int LANES  = 16;
    localparam int ADDR_W = 10;
    localparam int ACC_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           cfg_addr;
    logic [31:0]          cfg_wdata;
    logic                 cfg_wr;
    logic [31:0]          cfg_rdata;
    logic [ADDR_W-1:0]    sram_addr;
    logic                 sram_rd;
    logic [8*LANES-1:0]   sram_rdata;
    logic                 npu_start;
    logic                 npu_busy;
    logic                 npu_done;
    logic [ACC_W-1:0]     result;

    logic [8*LANES-1:0]   mem [DEPTH];

    int checkCount = 0;
    int errorCount = 0;

    npu_dot_engine #(.LANES(LANES), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wr     (cfg_wr),
        .cfg_rdata  (cfg_rdata),
        .sram_addr  (sram_addr),
        .sram_rd    (sram_rd),
        .sram_rdata (sram_rdata),
        .npu_start  (npu_start),
        .npu_busy   (npu_busy),
        .npu_done   (npu_done),
        .result     (result)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // SRAM model: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (sram_rd) sram_rdata <= mem[sram_addr];
    end

    // Global time limit so a stuck run can never hang the simulation
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cfgWrite(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wr    = 1'b1;
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    task automatic cfgRead(input logic [7:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic fillWords(input int addr, input int count, input logic [7:0] b);
        for (int i = 0; i < count; i++) mem[(addr + i) % DEPTH] = {LANES{b}};
    endtask

    task automatic fillRandom(input bit extremes);
        logic [8*LANES-1:0] word;
        for (int a = 0; a < DEPTH; a++) begin
            for (int j = 0; j < LANES; j++) begin
                word[8*j +: 8] = extremes ? (($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80)
                                          : 8'($urandom);
            end
            mem[a] = word;
        end
    endtask

    // Dot product of the first n elements of the two vectors, accumulated one
    // LANES-element chunk at a time and clamped to the signed ACC_W range
    function automatic void refModel(input int n, input int wb, input int ib,
                                     output longint res, output bit satFlag);
        longint acc, part, maxV, minV;
        logic [8*LANES-1:0] wWord, xWord;
        logic signed [7:0] wByte, xByte;
        int chunks;
        maxV    = (longint'(1) <<< (ACC_W - 1)) - 1;
        minV    = -maxV - 1;
        acc     = 0;
        satFlag = 1'b0;
        chunks  = (n + LANES - 1) / LANES;
        for (int c = 0; c < chunks; c++) begin
            wWord = mem[(wb + c) % DEPTH];
            xWord = mem[(ib + c) % DEPTH];
            part  = 0;
            for (int j = 0; j < LANES; j++) begin
                if (c * LANES + j < n) begin
                    wByte = wWord[8*j +: 8];
                    xByte = xWord[8*j +: 8];
                    part  = part + longint'(wByte) * longint'(xByte);
                end
            end
            acc = acc + part;
            if (acc > maxV) begin acc = maxV; satFlag = 1'b1; end
            if (acc < minV) begin acc = minV; satFlag = 1'b1; end
        end
`ifdef NPU_RELU_EN
        res = (acc < 0) ? 0 : acc;
`else
        res = acc;
`endif
    endfunction

    // Program a run, pulse start and count cycles and SRAM reads until done
    task automatic applyStimulus(input int n, input int wb, input int ib,
                                 output int latency, output int reads);
        bit done;
        cfgWrite(8'h00, 32'(n));
        cfgWrite(8'h04, 32'(wb));
        cfgWrite(8'h08, 32'(ib));
        cfgWrite(8'h10, 32'h0);
        @(negedge clk);
        npu_start = 1'b1;
        latency = 0;
        reads   = 0;
        done    = 1'b0;
        while (!done && latency < 2000) begin
            @(negedge clk);
            npu_start = 1'b0;
            latency++;
            if (sram_rd)  reads++;
            if (npu_done) done = 1'b1;
        end
        if (!done) checkOutput("doneTimeout", 64'(done), 64'(1));
    endtask

    task automatic verifyRun(input string tag, input int n, input int wb, input int ib);
        int latency, reads, chunks;
        longint expRes;
        bit expSat;
        logic [31:0] rd;
        chunks = (n + LANES - 1) / LANES;
        refModel(n, wb, ib, expRes, expSat);
        applyStimulus(n, wb, ib, latency, reads);
        checkOutput({tag, ".latency"}, 64'(latency), 64'((n == 0) ? 1 : 4 * chunks + 1));
        checkOutput({tag, ".reads"}, 64'(reads), 64'(2 * chunks));
        @(negedge clk);
        checkOutput({tag, ".result"}, 64'(result), 64'(expRes[ACC_W-1:0]));
        cfgRead(8'h0C, rd);
        checkOutput({tag, ".cfgResult"}, 64'(rd), 64'(expRes[31:0]));
        cfgRead(8'h10, rd);
        checkOutput({tag, ".status"}, 64'(rd), {61'b0, expSat, 2'b01});
    endtask

    initial begin
        logic [31:0] rd;
        longint expRes;
        bit expSat;
        int latency, doneCount, n, wb, ib;
        bit done;

        rst_n     = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        cfg_wr    = 1'b0;
        npu_start = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst.busy",   64'(npu_busy),  64'(0));
        checkOutput("rst.done",   64'(npu_done),  64'(0));
        checkOutput("rst.sramRd", 64'(sram_rd),   64'(0));
        checkOutput("rst.addr",   64'(sram_addr), 64'(0));
        checkOutput("rst.result", 64'(result),    64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        cfgRead(8'h00, rd); checkOutput("rst.numElements", 64'(rd), 64'd16);
        cfgRead(8'h04, rd); checkOutput("rst.weightBase",  64'(rd), 64'd0);
        cfgRead(8'h08, rd); checkOutput("rst.inputBase",   64'(rd), 64'd256);
        cfgRead(8'h0C, rd); checkOutput("rst.cfgResult",   64'(rd), 64'd0);
        cfgRead(8'h10, rd); checkOutput("rst.status",      64'(rd), 64'd0);
        cfgRead(8'h14, rd); checkOutput("rst.unmapped",    64'(rd), 64'd0);

        // Ones times twos over one full chunk
        fillWords(0, 1, 8'h01);
        fillWords(256, 1, 8'h02);
        verifyRun("r034", 16, 0, 256);
        checkOutput("r034.value", 64'(result), 64'd32);

        // Negative result (-1 * 3 * 16)
        fillWords(8, 1, 8'hFF);
        fillWords(300, 1, 8'h03);
        verifyRun("r035", 16, 8, 300);
        cfgRead(8'h0C, rd);
`ifdef NPU_RELU_EN
        checkOutput("r035.value", 64'(rd), 64'h0);
`else
        checkOutput("r035.value", 64'(rd), 64'hFFFFFFD0);
`endif

        // Partial final chunk: only 4 lanes of chunk 1 count
        fillWords(20, 2, 8'h01);
        fillWords(400, 2, 8'h01);
        verifyRun("r036", 20, 20, 400);
        checkOutput("r036.value", 64'(result), 64'd20);

        // Empty vector
        verifyRun("r037", 0, 0, 256);
        checkOutput("r037.value", 64'(result), 64'd0);

        // Positive saturation, then clearing status
        fillWords(60, 1, 8'h80);
        fillWords(700, 1, 8'h80);
        verifyRun("r038", 16, 60, 700);
        checkOutput("r038.clamp", 64'(result), 64'h7FFF);
        cfgRead(8'h10, rd); checkOutput("r038.satSet", 64'(rd), 64'd5);
        cfgWrite(8'h10, 32'h0);
        cfgRead(8'h10, rd); checkOutput("r038.satClear", 64'(rd), 64'd0);

        // Start held high: ignored while busy, restarts from IDLE after FIN;
        // a register write during the run is ignored
        fillRandom(1'b0);
        cfgWrite(8'h00, 32'd32);
        cfgWrite(8'h04, 32'd40);
        cfgWrite(8'h08, 32'd500);
        cfgWrite(8'h10, 32'h0);
        refModel(32, 40, 500, expRes, expSat);
        @(negedge clk);
        npu_start = 1'b1;
        latency = 0;
        done    = 1'b0;
        while (!done && latency < 200) begin
            @(negedge clk);
            latency++;
            if (latency == 2) begin
                cfg_addr  = 8'h00;
                cfg_wdata = 32'd7;
                cfg_wr    = 1'b1;
            end else begin
                cfg_wr = 1'b0;
            end
            if (npu_done) done = 1'b1;
        end
        checkOutput("b2b.latency", 64'(latency), 64'd9);
        @(negedge clk);
        checkOutput("b2b.idleGap", 64'(npu_busy), 64'd0);
        checkOutput("b2b.result", 64'(result), 64'(expRes[ACC_W-1:0]));
        @(negedge clk);
        checkOutput("b2b.restart", 64'(npu_busy), 64'd1);
        npu_start = 1'b0;
        latency = 1;
        while (!npu_done && latency < 200) begin
            @(negedge clk);
            latency++;
        end
        checkOutput("b2b.latency2", 64'(latency), 64'd9);
        @(negedge clk);
        checkOutput("b2b.result2", 64'(result), 64'(expRes[ACC_W-1:0]));
        cfgRead(8'h00, rd); checkOutput("b2b.busyWrite", 64'(rd), 64'd32);

        // Reset during the ACC state of chunk 0
        cfgWrite(8'h04, 32'd0);
        cfgWrite(8'h08, 32'd256);
        @(negedge clk);
        npu_start = 1'b1;
        @(negedge clk);
        npu_start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("r039.busyBefore", 64'(npu_busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("r039.busy",   64'(npu_busy), 64'd0);
        checkOutput("r039.done",   64'(npu_done), 64'd0);
        checkOutput("r039.result", 64'(result),   64'd0);
        cfgRead(8'h0C, rd); checkOutput("r039.cfgResult", 64'(rd), 64'd0);
        cfgRead(8'h00, rd); checkOutput("r039.numElements", 64'(rd), 64'd16);
        rst_n = 1'b1;
        doneCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (npu_done) doneCount++;
        end
        checkOutput("r039.noDone", 64'(doneCount), 64'd0);
        verifyRun("r039.fresh", 16, 0, 256);

        // Randomized runs, some with extreme bytes to provoke saturation
        for (int t = 0; t < 24; t++) begin
            fillRandom(t % 3 == 2);
            n  = int'($urandom_range(0, 72));
            wb = int'($urandom_range(0, DEPTH - 1));
            ib = int'($urandom_range(0, DEPTH - 1));
            verifyRun($sformatf("rand%0d", t), n, wb, ib);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
